codebook_stream_reader: RTL and testbench

- Sequencer that reads the symbol codebook ROM (37 rows × 8 columns, WIDTH-bit signed entries, 1-cycle synchronous read) and turns it into a valid/ready element stream for the ML detector datapath.
- On a start pulse it walks a contiguous range of rows, column 0..COLL-1 within each row.
- It absorbs the ROM read latency and downstream backpressure with a 2-entry skid buffer, so no element is lost or duplicated.

---
 rtl/codebook_pkg.sv | 28 ++
 rtl/codebook_stream_reader_if.sv | 25 ++
 rtl/cb_skid_buf.sv | 56 +++++
 rtl/codebook_stream_reader.sv | 184 ++++++++++++++++++
 tb/tb_codebook_stream_reader.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/codebook_pkg.sv
// Shared constants for the symbol codebook reader: ROM geometry, row map and FSM encoding.
package codebook_pkg;

   localparam int CB_WIDTH = 5;
   localparam int CB_DEPTH = 37;
   localparam int CB_COLL  = 8;

   localparam int ROW_VA1    = 0;
   localparam int ROW_A2B1   = 1;
   localparam int ROW_B2BV   = 2;
   localparam int ROW_S_BASE = 3;
   localparam int ROW_BS0    = 35;
   localparam int ROW_BS1    = 36;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   // S_k rows are interleaved real/imag pairs starting at ROW_S_BASE (k is 1-based).
   function automatic int s_real_row(input int k);
      return ROW_S_BASE + 2 * (k - 1);
   endfunction

   function automatic int s_imag_row(input int k);
      return ROW_S_BASE + 1 + 2 * (k - 1);
   endfunction

endpackage

// File: rtl/codebook_stream_reader_if.sv
// Valid/ready element stream carrying one codebook entry with its row/column tag.
interface codebook_stream_reader_if
   import codebook_pkg::*;
#(
   parameter int WIDTH     = CB_WIDTH,
   parameter int DEPTH_LOG = $clog2(CB_DEPTH),
   parameter int COLL_LOG  = $clog2(CB_COLL)
);
   logic signed [WIDTH-1:0]     out_data;
   logic        [DEPTH_LOG-1:0] out_row;
   logic        [COLL_LOG-1:0]  out_col;
   logic                        out_last;
   logic                        out_valid;
   logic                        out_ready;

   modport master (
      output out_data, out_row, out_col, out_last, out_valid,
      input  out_ready
   );

   modport slave (
      input  out_data, out_row, out_col, out_last, out_valid,
      output out_ready
   );
endinterface

// File: rtl/cb_skid_buf.sv
// Two-entry FIFO of tagged codebook elements; entry 0 is always the head.
module cb_skid_buf
   import codebook_pkg::*;
#(
   parameter int W = CB_WIDTH + 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  logic [W-1:0] din,
   output logic [W-1:0] head,
   output logic [1:0]   count
);
   logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
   logic [1:0]   cnt_q, cnt_d;
   logic [1:0]   level;

   always_comb begin
      e0_d  = e0_q;
      e1_d  = e1_q;
      cnt_d = cnt_q;
      level = pop ? cnt_q - 2'd1 : cnt_q;
      if (flush) begin
         cnt_d = 2'd0;
      end else begin
         if (pop) e0_d = e1_q;
         // A push lands behind whatever survives this cycle's pop.
         if (push) begin
            if (level == 2'd0) e0_d = din;
            else               e1_d = din;
         end
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e0_q  <= '0;
         e1_q  <= '0;
         cnt_q <= 2'd0;
      end else begin
         e0_q  <= e0_d;
         e1_q  <= e1_d;
         cnt_q <= cnt_d;
      end
   end

   assign head  = e0_q;
   assign count = cnt_q;
endmodule

// File: rtl/codebook_stream_reader.sv
// Walks a row range of the external codebook ROM and streams its entries over valid/ready,
// hiding the ROM's one-cycle read latency and consumer backpressure behind a skid buffer.
module codebook_stream_reader
   import codebook_pkg::*;
#(
   parameter int WIDTH     = CB_WIDTH,
   parameter int DEPTH     = CB_DEPTH,
   parameter int COLL      = CB_COLL,
   parameter int DEPTH_LOG = $clog2(DEPTH),
   parameter int COLL_LOG  = $clog2(COLL)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic        [DEPTH_LOG-1:0] start_row,
   input  logic        [DEPTH_LOG:0]   num_rows,
   input  logic                        abort,
   output logic        [DEPTH_LOG-1:0] rom_row,
   output logic        [COLL_LOG-1:0]  rom_collum,
   input  logic signed [WIDTH-1:0]     rom_data,
   codebook_stream_reader_if.master    strm,
   output logic                        busy,
   output logic                        done,
   output logic                        range_err
);
   localparam int SUM_W = DEPTH_LOG + 2;
   localparam int EW    = WIDTH + DEPTH_LOG + COLL_LOG + 1;

   logic [1:0]           state_q, state_d;
   logic [DEPTH_LOG-1:0] row_q, row_d, rom_row_q, rom_row_d;
   logic [COLL_LOG-1:0]  col_q, col_d, rom_col_q, rom_col_d;
   logic [SUM_W-1:0]     end_row_q, end_row_d;
   logic inflight_q, inflight_d, infl_last_q, infl_last_d;
   logic busy_q, busy_d, done_q, done_d, range_err_q, range_err_d;

   logic [SUM_W-1:0]     req_sum, req_end, iss_end;
   logic                 req_empty, issue_en, is_last, push, pop, flush;
   logic [DEPTH_LOG-1:0] iss_row;
   logic [COLL_LOG-1:0]  iss_col;
   logic [2:0]           occ;
   logic [1:0]           buf_count;
   logic [EW-1:0]        buf_din, buf_head;
   logic                 head_valid, head_last;

   assign req_sum   = SUM_W'(start_row) + SUM_W'(num_rows);
   assign req_end   = (req_sum > SUM_W'(DEPTH)) ? SUM_W'(DEPTH) : req_sum;
   assign req_empty = (num_rows == '0) || (SUM_W'(start_row) >= SUM_W'(DEPTH));

   assign head_valid = (buf_count != 2'd0);
   assign head_last  = buf_head[0];
   assign pop        = head_valid & strm.out_ready;
   // Slots already committed: buffered + the ROM read in flight, less what leaves now.
   assign occ        = 3'(buf_count) + 3'(inflight_q) - 3'(pop);

   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      col_d       = col_q;
      end_row_d   = end_row_q;
      rom_row_d   = rom_row_q;
      rom_col_d   = rom_col_q;
      inflight_d  = 1'b0;
      infl_last_d = infl_last_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      range_err_d = range_err_q;
      push        = inflight_q;
      flush       = 1'b0;
      issue_en    = 1'b0;
      iss_row     = row_q;
      iss_col     = col_q;
      iss_end     = end_row_q;
      is_last     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               range_err_d = (req_sum > SUM_W'(DEPTH));
               if (req_empty) begin
                  done_d = 1'b1;
               end else begin
                  // First address goes out on the accepting edge to save a cycle of latency.
                  iss_row   = start_row;
                  iss_col   = '0;
                  iss_end   = req_end;
                  end_row_d = req_end;
                  issue_en  = 1'b1;
                  busy_d    = 1'b1;
                  state_d   = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: issue_en = (occ < 3'd2);
         ST_DRAIN: begin
            if (pop && head_last) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (issue_en) begin
         is_last     = (SUM_W'(iss_row) == iss_end - SUM_W'(1)) &&
                       (iss_col == COLL_LOG'(COLL - 1));
         rom_row_d   = iss_row;
         rom_col_d   = iss_col;
         inflight_d  = 1'b1;
         infl_last_d = is_last;
         if (iss_col == COLL_LOG'(COLL - 1)) begin
            col_d = '0;
            row_d = iss_row + DEPTH_LOG'(1);
         end else begin
            col_d = iss_col + COLL_LOG'(1);
            row_d = iss_row;
         end
         if (is_last) state_d = ST_DRAIN;
      end

      if (abort && (state_q != ST_IDLE)) begin
         state_d    = ST_IDLE;
         busy_d     = 1'b0;
         done_d     = 1'b0;
         inflight_d = 1'b0;
         push       = 1'b0;
         flush      = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         row_q       <= '0;
         col_q       <= '0;
         end_row_q   <= '0;
         rom_row_q   <= '0;
         rom_col_q   <= '0;
         inflight_q  <= 1'b0;
         infl_last_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         range_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         col_q       <= col_d;
         end_row_q   <= end_row_d;
         rom_row_q   <= rom_row_d;
         rom_col_q   <= rom_col_d;
         inflight_q  <= inflight_d;
         infl_last_q <= infl_last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         range_err_q <= range_err_d;
      end
   end

   // ROM data returns while its address register still holds the matching tag.
   assign buf_din = {rom_data, rom_row_q, rom_col_q, infl_last_q};

   cb_skid_buf #(.W(EW)) u_skid (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .din   (buf_din),
      .head  (buf_head),
      .count (buf_count)
   );

   assign strm.out_data  = buf_head[EW-1 -: WIDTH];
   assign strm.out_row   = buf_head[COLL_LOG + DEPTH_LOG : COLL_LOG + 1];
   assign strm.out_col   = buf_head[COLL_LOG:1];
   assign strm.out_last  = buf_head[0];
   assign strm.out_valid = head_valid;

   assign rom_row    = rom_row_q;
   assign rom_collum = rom_col_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign range_err  = range_err_q;
endmodule

// File: tb/tb_codebook_stream_reader.sv
// Directed bench: a behavioural ROM feeds the reader; expected beats are queued at each start
// and popped as the stream is accepted.
module tb_codebook_stream_reader;
   import codebook_pkg::*;

   localparam int WIDTH = CB_WIDTH;
   localparam int DEPTH = CB_DEPTH;
   localparam int COLL  = CB_COLL;
   localparam int DL    = $clog2(DEPTH);
   localparam int CL    = $clog2(COLL);
   localparam int EW    = WIDTH + DL + CL + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic [DL-1:0] start_row = '0;
   logic [DL:0]   num_rows = '0;
   logic [DL-1:0] rom_row;
   logic [CL-1:0] rom_collum;
   logic signed [WIDTH-1:0] rom_data;
   logic busy, done, range_err;
   logic [EW-1:0] head;

   codebook_stream_reader_if #(.WIDTH(WIDTH), .DEPTH_LOG(DL), .COLL_LOG(CL)) strm ();

   codebook_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .COLL(COLL)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .start_row  (start_row),
      .num_rows   (num_rows),
      .abort      (abort),
      .rom_row    (rom_row),
      .rom_collum (rom_collum),
      .rom_data   (rom_data),
      .strm       (strm),
      .busy       (busy),
      .done       (done),
      .range_err  (range_err)
   );

   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] rom_val(input int r, input int c);
      logic [8*WIDTH-1:0] w;
      case (r)
         0:       w = {5'h1D, 5'h1F, 5'h01, 5'h03, 5'h01, 5'h00, 5'h00, 5'h01};
         5:       w = {5'h01, 5'h01, 5'h1F, 5'h01, 5'h01, 5'h00, 5'h00, 5'h01};
         35:      return WIDTH'(c);
         36:      return WIDTH'(8 + c);
         default: return WIDTH'((r * 7 + c * 3) % 32);
      endcase
      return w[8*WIDTH-1 - WIDTH*c -: WIDTH];
   endfunction

   // The DUT's address register is the ROM's input register, so data follows one cycle later.
   always_comb rom_data = rom_val(int'(rom_row), int'(rom_collum));

   assign head = {strm.out_data, strm.out_row, strm.out_col, strm.out_last};

   logic [EW-1:0] exp_q[$];
   int checks = 0, errors = 0;
   int cyc = 0, beats = 0, done_cnt = 0, done_cyc = -1, start_cyc = 0;
   int first_valid_cyc = -1, last_beat_cyc = -1;
   int stall_after = -1, stall_left = 0;
   bit busy_seen = 0, stall_prev = 0;
   logic [EW-1:0] stall_val = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      logic [EW-1:0] e;
      @(negedge clk);
      if (busy) busy_seen = 1;
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (stall_prev) chk("stall_hold", {strm.out_valid, head}, {1'b1, stall_val});
      if (strm.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (strm.out_valid && strm.out_ready) begin
         chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("beat", 32'(head), 32'(e));
         end
         beats++;
         last_beat_cyc = cyc;
      end
      stall_prev = strm.out_valid && !strm.out_ready;
      stall_val  = head;
      cyc++;
      @(posedge clk);
      #1;
      if (stall_after >= 0 && beats == stall_after && stall_left > 0) begin
         strm.out_ready = 1'b0;
         stall_left--;
      end else begin
         strm.out_ready = 1'b1;
      end
   endtask

   task automatic queue_req(input int srow, input int nrows);
      int end_r;
      end_r = srow + nrows;
      if (end_r > DEPTH) end_r = DEPTH;
      for (int r = srow; r < end_r; r++)
         for (int c = 0; c < COLL; c++)
            exp_q.push_back({rom_val(r, c), DL'(r), CL'(c), (r == end_r - 1) && (c == COLL - 1)});
      beats = 0; done_cnt = 0; done_cyc = -1; first_valid_cyc = -1; busy_seen = 0;
      start_row = DL'(srow);
      num_rows  = (DL+1)'(nrows);
      start     = 1'b1;
      start_cyc = cyc;
      tick();
      start = 1'b0;
   endtask

   task automatic run_req(input int srow, input int nrows, input logic exp_rerr,
                          input bit full_rate, input int restart_at);
      int nexp;
      bit restarted;
      nexp = exp_q.size();
      queue_req(srow, nrows);
      nexp = exp_q.size() - nexp + (beats);
      restarted = 0;
      for (int k = 0; k < 300 && done_cnt == 0; k++) begin
         if (restart_at >= 0 && beats == restart_at && !restarted) begin
            start = 1'b1; start_row = '0; num_rows = (DL+1)'(1);
            restarted = 1;
            tick();
            start = 1'b0;
         end else begin
            tick();
         end
      end
      chk("done_seen", 32'(done_cnt), 32'd1);
      repeat (4) tick();
      chk("beats", 32'(beats), 32'(nexp));
      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      chk("done_once", 32'(done_cnt), 32'd1);
      chk("range_err", 32'(range_err), 32'(exp_rerr));
      chk("busy_idle", 32'(busy), 32'd0);
      if (nexp == 0) begin
         chk("zero_done_lat", 32'(done_cyc - start_cyc), 32'd1);
         chk("zero_no_busy", 32'(busy_seen), 32'd0);
      end else begin
         chk("done_after_last", 32'(done_cyc), 32'(last_beat_cyc + 1));
         if (full_rate) begin
            chk("first_valid_lat", 32'(first_valid_cyc - start_cyc), 32'd2);
            chk("throughput", 32'(done_cyc - first_valid_cyc), 32'(nexp));
         end
      end
   endtask

   initial begin
      int saved;
      strm.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 32'(strm.out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_rerr", 32'(range_err), 32'd0);
      chk("rst_rom_addr", {rom_row, rom_collum}, 32'd0);
      chk("rst_head", 32'(head), 32'd0);
      rst = 1'b0;
      repeat (2) tick();

      // Single row, full rate.
      run_req(0, 1, 1'b0, 1, -1);
      // Two rows at the top of the ROM, with a start attempt mid-stream that must be ignored.
      run_req(35, 2, 1'b0, 1, 5);
      // Backpressure: three stalled cycles after beat 2.
      stall_after = 2; stall_left = 3;
      run_req(5, 1, 1'b0, 0, -1);
      stall_after = -1;
      // Zero-length and clamped requests.
      run_req(7, 0, 1'b0, 0, -1);
      run_req(36, 2, 1'b1, 1, -1);
      run_req(40, 3, 1'b1, 0, -1);

      // Abort after beat 3 of a 4-row read, with a simultaneous start that must lose.
      queue_req(10, 4);
      for (int k = 0; k < 100 && beats < 3; k++) tick();
      abort = 1'b1; start = 1'b1; start_row = DL'(2); num_rows = (DL+1)'(1);
      done_cnt = 0;
      tick();
      abort = 1'b0; start = 1'b0;
      exp_q.delete();
      chk("abort_valid", 32'(strm.out_valid), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      saved = beats;
      repeat (6) tick();
      chk("abort_no_beats", 32'(beats), 32'(saved));
      chk("abort_no_done", 32'(done_cnt), 32'd0);
      run_req(20, 1, 1'b0, 1, -1);

      // Asynchronous reset while beat 5 is on the bus.
      queue_req(35, 2);
      for (int k = 0; k < 100 && beats < 4; k++) tick();
      rst = 1'b1;
      #1;
      chk("arst_valid", 32'(strm.out_valid), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_rom_addr", {rom_row, rom_collum}, 32'd0);
      chk("arst_head", 32'(head), 32'd0);
      exp_q.delete();
      done_cnt = 0;
      tick();
      rst = 1'b0;
      saved = beats;
      repeat (5) tick();
      chk("arst_no_beats", 32'(beats), 32'(saved));
      chk("arst_no_done", 32'(done_cnt), 32'd0);
      run_req(0, 1, 1'b0, 1, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
